// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Single-outstanding instruction fetch sequencer with redirect squash.
//            Optional macro MISALIGN_TRAP_EN traps misaligned redirects.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic [31:0] pc_out,
    output logic        fetch_exc
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_fetch_pc;
    logic [31:0] w_fetch_pc_nxt;
    logic [31:0] r_req_pc;
    logic [31:0] w_req_pc_nxt;
    logic [31:0] r_inst;
    logic [31:0] w_inst_nxt;
    logic [31:0] r_inst_pc;
    logic [31:0] w_inst_pc_nxt;
    logic        r_discard;
    logic        w_discard_nxt;
    logic        w_imem_req;
    logic        w_inst_valid;
    logic [31:0] w_redirect_target;

`ifdef MISALIGN_TRAP_EN
    logic w_misaligned;
    logic r_fetch_exc;

    assign w_misaligned      = (redirect_pc[1:0] != 2'b00);
    assign w_redirect_target = w_misaligned ? EXC_VECTOR : redirect_pc;

    // Flag lives for exactly the cycle after the offending redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_exc <= 1'b0;
        end else begin
            r_fetch_exc <= redirect_valid & w_misaligned;
        end
    end

    assign fetch_exc = r_fetch_exc;
`else
    logic w_unused_exc_vector;

    assign w_unused_exc_vector = ^EXC_VECTOR;
    assign w_redirect_target   = redirect_pc;
    assign fetch_exc           = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FETCH;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= 32'h0000_0000;
            r_inst     <= 32'h0000_0000;
            r_inst_pc  <= 32'h0000_0000;
            r_discard  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_req_pc   <= w_req_pc_nxt;
            r_inst     <= w_inst_nxt;
            r_inst_pc  <= w_inst_pc_nxt;
            r_discard  <= w_discard_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_req_pc_nxt   = r_req_pc;
        w_inst_nxt     = r_inst;
        w_inst_pc_nxt  = r_inst_pc;
        w_discard_nxt  = r_discard;
        w_imem_req     = 1'b0;
        w_inst_valid   = 1'b0;

        case (r_state)
            ST_FETCH: begin
                w_imem_req = ~redirect_valid;
                if (redirect_valid) begin
                    w_fetch_pc_nxt = w_redirect_target;
                end else if (imem_ready) begin
                    w_req_pc_nxt   = r_fetch_pc;
                    w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                    w_state_nxt    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (redirect_valid) begin
                    w_fetch_pc_nxt = w_redirect_target;
                    // A response arriving with the redirect is dropped on the spot;
                    // otherwise the one still in flight must be dropped later.
                    if (imem_rvalid) begin
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = ST_FETCH;
                    end else begin
                        w_discard_nxt = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (r_discard) begin
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = ST_FETCH;
                    end else begin
                        w_inst_nxt    = imem_rdata;
                        w_inst_pc_nxt = r_req_pc;
                        w_state_nxt   = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                w_inst_valid = ~redirect_valid;
                if (redirect_valid) begin
                    w_fetch_pc_nxt = w_redirect_target;
                    w_state_nxt    = ST_FETCH;
                end else if (inst_ready) begin
                    w_state_nxt = ST_FETCH;
                end
            end

            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    assign imem_req   = w_imem_req;
    assign imem_addr  = r_fetch_pc;
    assign inst_valid = w_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign pc_out     = r_fetch_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Directed self-checking bench for fetch_ctrl with a flag-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam logic [31:0] C_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] C_EXC_VECTOR = 32'h0000_0380;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [31:0] pc_out;
    logic        fetch_exc;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_ctrl #(
        .RESET_PC   (C_RESET_PC),
        .EXC_VECTOR (C_EXC_VECTOR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .pc_out         (pc_out),
        .fetch_exc      (fetch_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: fetch address, one outstanding-request flag, a stale flag for
    // a squashed response, and an occupied holding slot.
    logic        started = 1'b0;
    logic [31:0] m_fetch_pc;
    logic [31:0] m_req_addr;
    logic        m_pending;
    logic        m_stale;
    logic        m_held;
    logic [31:0] m_inst;
    logic [31:0] m_inst_pc;
    logic        m_exc;

    // Memory stub: answers mem_lat cycles after acceptance with addr-dependent data.
    int          mem_lat  = 1;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = 32'h0;
    logic        force_rv = 1'b0;

    assign imem_rvalid = force_rv | (mem_cnt == 1);
    assign imem_rdata  = force_rv ? 32'hDEAD_BEEF : (32'h2000_0001 + mem_addr);

    logic exp_req;
    logic exp_iv;
    assign exp_req = !m_pending && !m_held && !redirect_valid;
    assign exp_iv  = m_held && !redirect_valid;

    function automatic logic [31:0] target_of(input logic [31:0] pc);
`ifdef MISALIGN_TRAP_EN
        return (pc[1:0] != 2'b00) ? C_EXC_VECTOR : pc;
`else
        return pc;
`endif
    endfunction

    function automatic logic trap_of(input logic [31:0] pc);
`ifdef MISALIGN_TRAP_EN
        return pc[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin : p_model
        logic [31:0] t_pc;
        logic        t_p;
        logic        t_s;
        logic        t_h;
        logic        t_acc;
        logic        t_rv;
        if (rst) begin
            started    <= 1'b1;
            m_fetch_pc <= C_RESET_PC;
            m_req_addr <= 32'h0;
            m_pending  <= 1'b0;
            m_stale    <= 1'b0;
            m_held     <= 1'b0;
            m_exc      <= 1'b0;
            mem_cnt    <= 0;
        end else begin
            t_pc  = m_fetch_pc;
            t_p   = m_pending;
            t_s   = m_stale;
            t_h   = m_held;
            t_acc = exp_req && imem_ready;
            t_rv  = imem_rvalid && m_pending;
            if (redirect_valid) begin
                t_pc = target_of(redirect_pc);
                t_h  = 1'b0;
                if (t_p) begin
                    if (t_rv) begin
                        t_p = 1'b0;
                        t_s = 1'b0;
                    end else begin
                        t_s = 1'b1;
                    end
                end
                m_exc <= trap_of(redirect_pc);
            end else begin
                m_exc <= 1'b0;
                if (t_h && inst_ready) t_h = 1'b0;
                if (t_rv) begin
                    t_p = 1'b0;
                    if (t_s) begin
                        t_s = 1'b0;
                    end else begin
                        t_h = 1'b1;
                        m_inst    <= imem_rdata;
                        m_inst_pc <= m_req_addr;
                    end
                end
                if (t_acc) begin
                    m_req_addr <= t_pc;
                    t_pc = t_pc + 32'd4;
                    t_p  = 1'b1;
                end
            end
            m_fetch_pc <= t_pc;
            m_pending  <= t_p;
            m_stale    <= t_s;
            m_held     <= t_h;
            if (t_acc) begin
                mem_cnt  <= mem_lat;
                mem_addr <= m_fetch_pc;
            end else if (mem_cnt != 0) begin
                mem_cnt <= mem_cnt - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
            if (exp_req) chk("imem_addr", imem_addr, m_fetch_pc);
            chk("inst_valid", {31'b0, inst_valid}, {31'b0, exp_iv});
            if (exp_iv) begin
                chk("inst", inst, m_inst);
                chk("inst_pc", inst_pc, m_inst_pc);
            end
            chk("pc_out", pc_out, m_fetch_pc);
            chk("fetch_exc", {31'b0, fetch_exc}, {31'b0, m_exc});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ready     = 1'b1;
        inst_ready     = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Back-to-back fetches: 3-cycle cadence
        @(negedge clk);
        chk("lit_first_req", {31'b0, imem_req}, 32'd1);
        chk("lit_first_addr", imem_addr, 32'h0);
        chk("lit_reset_iv", {31'b0, inst_valid}, 32'd0);
        tick(); tick();
        @(negedge clk);
        chk("lit_iv0", {31'b0, inst_valid}, 32'd1);
        chk("lit_inst0", inst, 32'h2000_0001);
        chk("lit_ipc0", inst_pc, 32'h0);
        tick();
        @(negedge clk);
        chk("lit_addr4", imem_addr, 32'h4);
        tick(); tick();
        @(negedge clk);
        chk("lit_inst1", inst, 32'h2000_0005);
        chk("lit_ipc1", inst_pc, 32'h4);
        tick();
        @(negedge clk);
        chk("lit_addr8", imem_addr, 32'h8);

        // Decode stall for 5 cycles
        tick();
        inst_ready = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("lit_stall_iv", {31'b0, inst_valid}, 32'd1);
            chk("lit_stall_ipc", inst_pc, 32'h8);
            chk("lit_stall_req", {31'b0, imem_req}, 32'd0);
            tick();
        end
        inst_ready = 1'b1;
        mem_lat    = 3;
        tick();
        @(negedge clk);
        chk("lit_addr12", imem_addr, 32'hC);

        // Redirect in WAIT; stale response arrives two cycles later
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        mem_lat        = 1;
        @(negedge clk);
        chk("lit_pc_redir", pc_out, 32'h100);
        tick();
        @(negedge clk);
        chk("lit_stale_iv", {31'b0, inst_valid}, 32'd0);
        tick();
        @(negedge clk);
        chk("lit_req_100", {31'b0, imem_req}, 32'd1);
        chk("lit_addr_100", imem_addr, 32'h100);

        // Redirect in HOLD with decode ready the same cycle
        tick(); tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        @(negedge clk);
        chk("lit_hold_redir_iv", {31'b0, inst_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        mem_lat        = 3;
        @(negedge clk);
        chk("lit_addr_40", imem_addr, 32'h40);
        chk("lit_iv_after_40", {31'b0, inst_valid}, 32'd0);

        // Reset mid-WAIT, then a late response
        tick();
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        imem_ready = 1'b0;
        force_rv   = 1'b1;
        @(negedge clk);
        chk("lit_rst_req", {31'b0, imem_req}, 32'd1);
        chk("lit_rst_addr", imem_addr, C_RESET_PC);
        chk("lit_rst_iv", {31'b0, inst_valid}, 32'd0);
        tick();
        force_rv       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        @(negedge clk);
        chk("lit_late_iv", {31'b0, inst_valid}, 32'd0);

        // Misaligned redirect
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
`ifdef MISALIGN_TRAP_EN
        chk("lit_mis_exc", {31'b0, fetch_exc}, 32'd1);
        chk("lit_mis_addr", imem_addr, 32'h380);
`else
        chk("lit_mis_exc", {31'b0, fetch_exc}, 32'd0);
        chk("lit_mis_addr", imem_addr, 32'h102);
`endif
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        imem_ready     = 1'b1;
        mem_lat        = 1;
        @(negedge clk);
        chk("lit_exc_clear", {31'b0, fetch_exc}, 32'd0);

        // Address wrap at the top of memory
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("lit_addr_top", imem_addr, 32'hFFFF_FFFC);
        tick();
        @(negedge clk);
        chk("lit_wrap_pc", pc_out, 32'h0);

        // Mixed directed traffic checked by the model
        for (int i = 0; i < 40; i++) begin
            tick();
            inst_ready     = (i % 4) != 1;
            imem_ready     = (i % 5) != 2;
            redirect_valid = (i % 7) == 3;
            redirect_pc    = 32'h0000_0200 + (32'(i) << 4) + (((i % 14) == 3) ? 32'd2 : 32'd0);
            mem_lat        = 1 + (i % 3);
        end
        tick();
        redirect_valid = 1'b0;
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
